// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the halt/drain FSM encoding used by the
// hazard stall unit and its load scoreboard.
package pipeline_pkg;

    localparam int REG_SIZE         = 5;
    localparam int NUM_REGS         = 32;
    localparam int LOAD_LAT_DEFAULT = 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

endpackage

// File: rtl/load_scoreboard.sv
// Per-register countdown of in-flight load results. A nonzero count means the
// register's value cannot be forwarded yet.
module load_scoreboard
    import pipeline_pkg::*;
#(
    parameter int REG_SIZE = pipeline_pkg::REG_SIZE,
    parameter int NUM_REGS = pipeline_pkg::NUM_REGS,
    parameter int LOAD_LAT = pipeline_pkg::LOAD_LAT_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_issue,
    input  logic [REG_SIZE-1:0] i_issue_rd,
    input  logic [REG_SIZE-1:0] i_rs,
    input  logic [REG_SIZE-1:0] i_rt,
    output logic                o_rs_busy,
    output logic                o_rt_busy,
    output logic                o_all_zero
);

    localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    logic [CW-1:0] cnt_q [NUM_REGS];
    logic [CW-1:0] cnt_d [NUM_REGS];

    // Reload on issue takes precedence over the free-running decrement.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
            if (i != 0 && i_issue && i_issue_rd == REG_SIZE'(i)) begin
                cnt_d[i] = CW'(LOAD_LAT);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        o_rs_busy  = (i_rs != '0) && (cnt_q[i_rs] != '0);
        o_rt_busy  = (i_rt != '0) && (cnt_q[i_rt] != '0);
        o_all_zero = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cnt_q[i] != '0) begin
                o_all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, branch flush and debug-halt drain control for the 5-stage
// pipeline. Control outputs are combinational from registered state and ID/EX.
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int REG_SIZE = pipeline_pkg::REG_SIZE,
    parameter int NUM_REGS = pipeline_pkg::NUM_REGS,
    parameter int LOAD_LAT = pipeline_pkg::LOAD_LAT_DEFAULT,
    parameter int CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_id_valid,
    input  logic [REG_SIZE-1:0] i_id_rs,
    input  logic [REG_SIZE-1:0] i_id_rt,
    input  logic                i_id_use_rs,
    input  logic                i_id_use_rt,
    input  logic                i_id_is_store,
    input  logic [REG_SIZE-1:0] i_id_rd,
    input  logic                i_id_write_reg,
    input  logic                i_id_mem_read,
    input  logic                i_branch_taken,
    input  logic                i_halt_req,
    output logic                o_stall_pc,
    output logic                o_stall_if_id,
    output logic                o_bubble_id_ex,
    output logic                o_flush_if_id,
    output logic                o_halt_ack,
    output logic [CNT_W-1:0]    o_stall_cycles
);

    halt_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_busy, rt_busy, all_zero;
    logic hazard, in_run, issue_load;

    // Store data (rt) is forwarded from WB, so it never blocks issue.
    assign hazard = i_id_valid &
                    ((i_id_use_rs & rs_busy) |
                     (i_id_use_rt & rt_busy & ~i_id_is_store));
    assign in_run = (state_q == ST_RUN);
    assign issue_load = in_run & i_id_valid & ~i_branch_taken & ~hazard &
                        i_id_mem_read & i_id_write_reg & (i_id_rd != '0);

    load_scoreboard #(
        .REG_SIZE (REG_SIZE),
        .NUM_REGS (NUM_REGS),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_issue    (issue_load),
        .i_issue_rd (i_id_rd),
        .i_rs       (i_id_rs),
        .i_rt       (i_id_rt),
        .o_rs_busy  (rs_busy),
        .o_rt_busy  (rt_busy),
        .o_all_zero (all_zero)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (i_halt_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!i_halt_req)   state_d = ST_RUN;
                else if (all_zero) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (!i_halt_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Flush beats drain/halt, which beats a load-use hazard.
    always_comb begin
        o_stall_pc     = 1'b0;
        o_stall_if_id  = 1'b0;
        o_bubble_id_ex = 1'b0;
        o_flush_if_id  = 1'b0;
        o_halt_ack     = 1'b0;
        if (i_reset_n) begin
            o_halt_ack = (state_q == ST_HALTED);
            if (i_branch_taken) begin
                o_flush_if_id  = 1'b1;
                o_bubble_id_ex = 1'b1;
            end else if (!in_run || hazard) begin
                o_stall_pc     = 1'b1;
                o_stall_if_id  = 1'b1;
                o_bubble_id_ex = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_run && hazard && !i_branch_taken && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: two instances (LOAD_LAT 1 and 3),
// directed instruction streams with hand-computed expected control outputs.
module tb_hazard_stall_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       is_store;
        logic [4:0] rd;
        logic       write_reg;
        logic       mem_read;
    } in_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic        stall;
        logic        bub;
        logic        flush;
        logic        ack;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    in_t  in1, in3;
    logic br1, br3, halt1, halt3;

    logic        o1_spc, o1_sif, o1_bub, o1_fl, o1_ack;
    logic        o3_spc, o3_sif, o3_bub, o3_fl, o3_ack;
    logic [31:0] o1_cnt, o3_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    failures;

    hazard_stall_unit #(.LOAD_LAT(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_id_valid(in1.valid), .i_id_rs(in1.rs), .i_id_rt(in1.rt),
        .i_id_use_rs(in1.use_rs), .i_id_use_rt(in1.use_rt),
        .i_id_is_store(in1.is_store), .i_id_rd(in1.rd),
        .i_id_write_reg(in1.write_reg), .i_id_mem_read(in1.mem_read),
        .i_branch_taken(br1), .i_halt_req(halt1),
        .o_stall_pc(o1_spc), .o_stall_if_id(o1_sif), .o_bubble_id_ex(o1_bub),
        .o_flush_if_id(o1_fl), .o_halt_ack(o1_ack), .o_stall_cycles(o1_cnt)
    );

    hazard_stall_unit #(.LOAD_LAT(3)) dut3 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_id_valid(in3.valid), .i_id_rs(in3.rs), .i_id_rt(in3.rt),
        .i_id_use_rs(in3.use_rs), .i_id_use_rt(in3.use_rt),
        .i_id_is_store(in3.is_store), .i_id_rd(in3.rd),
        .i_id_write_reg(in3.write_reg), .i_id_mem_read(in3.mem_read),
        .i_branch_taken(br3), .i_halt_req(halt3),
        .o_stall_pc(o3_spc), .o_stall_if_id(o3_sif), .o_bubble_id_ex(o3_bub),
        .o_flush_if_id(o3_fl), .o_halt_ack(o3_ack), .o_stall_cycles(o3_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t f_nop();
        in_t r;
        r = '0;
        return r;
    endfunction

    function automatic in_t f_lw(input logic [4:0] rd, input logic [4:0] base);
        in_t r;
        r = '0;
        r.valid = 1'b1; r.rs = base; r.use_rs = 1'b1;
        r.rd = rd; r.write_reg = 1'b1; r.mem_read = 1'b1;
        return r;
    endfunction

    function automatic in_t f_alu(input logic [4:0] rd, input logic [4:0] rs,
                                  input logic [4:0] rt);
        in_t r;
        r = '0;
        r.valid = 1'b1; r.rs = rs; r.rt = rt; r.use_rs = 1'b1; r.use_rt = 1'b1;
        r.rd = rd; r.write_reg = 1'b1;
        return r;
    endfunction

    function automatic in_t f_sw(input logic [4:0] base, input logic [4:0] data);
        in_t r;
        r = '0;
        r.valid = 1'b1; r.rs = base; r.rt = data; r.use_rs = 1'b1;
        r.use_rt = 1'b1; r.is_store = 1'b1;
        return r;
    endfunction

    // Drive one cycle of stimulus into the selected instance and queue the
    // outputs expected from it during that cycle.
    task automatic applyStimulus(input int sel, input logic rst, input in_t ins,
                                 input logic br, input logic halt,
                                 input logic e_stall, input logic e_bub,
                                 input logic e_flush, input logic e_ack,
                                 input int e_cnt, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        in1 = f_nop(); br1 = 1'b0; halt1 = 1'b0;
        in3 = f_nop(); br3 = 1'b0; halt3 = 1'b0;
        if (sel == 1) begin
            in1 = ins; br1 = br; halt1 = halt;
        end else begin
            in3 = ins; br3 = br; halt3 = halt;
        end
        e.sel = 2'(sel); e.stall = e_stall; e.bub = e_bub;
        e.flush = e_flush; e.ack = e_ack; e.cnt = 32'(e_cnt);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        logic spc, sif, bub, fl, ack;
        logic [31:0] cnt;
        if (e.sel == 2'd1) begin
            spc = o1_spc; sif = o1_sif; bub = o1_bub; fl = o1_fl; ack = o1_ack; cnt = o1_cnt;
        end else begin
            spc = o3_spc; sif = o3_sif; bub = o3_bub; fl = o3_fl; ack = o3_ack; cnt = o3_cnt;
        end
        checks++;
        if (spc !== e.stall || sif !== e.stall || bub !== e.bub ||
            fl !== e.flush || ack !== e.ack || cnt !== e.cnt) begin
            failures++;
            $display("[TB] FAIL %s: got stall_pc=%b stall_if_id=%b bubble=%b flush=%b ack=%b cycles=%0d, want stall=%b bubble=%b flush=%b ack=%b cycles=%0d",
                     name, spc, sif, bub, fl, ack, cnt,
                     e.stall, e.bub, e.flush, e.ack, e.cnt);
        end
    endtask

    // Monitor: compare the outputs of every queued cycle mid-period.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checkOutput(e, n);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        in1 = f_nop(); in3 = f_nop();
        br1 = 1'b0; br3 = 1'b0; halt1 = 1'b0; halt3 = 1'b0;

        // LOAD_LAT = 1 instance
        applyStimulus(1, 0, f_nop(),        1, 0, 0,0,0,0, 0, "reset_gate");
        applyStimulus(1, 1, f_nop(),        0, 0, 0,0,0,0, 0, "idle");
        applyStimulus(1, 1, f_lw(3,0),      0, 0, 0,0,0,0, 0, "lw3_issue");
        applyStimulus(1, 1, f_alu(4,3,5),   0, 0, 1,1,0,0, 0, "ldu_stall");
        applyStimulus(1, 1, f_alu(4,3,5),   0, 0, 0,0,0,0, 1, "ldu_release");
        applyStimulus(1, 1, f_lw(3,0),      0, 0, 0,0,0,0, 1, "lw3_again");
        applyStimulus(1, 1, f_nop(),        0, 0, 0,0,0,0, 1, "nop_slot");
        applyStimulus(1, 1, f_alu(4,3,3),   0, 0, 0,0,0,0, 1, "two_slot_use");
        applyStimulus(1, 1, f_lw(3,0),      0, 0, 0,0,0,0, 1, "lw3_before_sw");
        applyStimulus(1, 1, f_sw(6,3),      0, 0, 0,0,0,0, 1, "sw_data_exempt");
        applyStimulus(1, 1, f_lw(3,0),      0, 0, 0,0,0,0, 1, "lw3_before_swbase");
        applyStimulus(1, 1, f_sw(3,7),      0, 0, 1,1,0,0, 1, "sw_base_stall");
        applyStimulus(1, 1, f_sw(3,7),      0, 0, 0,0,0,0, 2, "sw_base_release");
        applyStimulus(1, 1, f_lw(0,0),      0, 0, 0,0,0,0, 2, "lw_r0");
        applyStimulus(1, 1, f_alu(4,0,0),   0, 0, 0,0,0,0, 2, "r0_untracked");
        applyStimulus(1, 1, f_lw(3,0),      0, 0, 0,0,0,0, 2, "lw3_before_branch");
        applyStimulus(1, 1, f_lw(9,3),      1, 0, 0,1,1,0, 2, "flush_wins");
        applyStimulus(1, 1, f_alu(10,9,9),  0, 0, 0,0,0,0, 2, "killed_no_track");
        applyStimulus(1, 1, f_lw(3,0),      0, 0, 0,0,0,0, 2, "lw3_before_reset");
        applyStimulus(1, 1, f_alu(4,3,5),   0, 0, 1,1,0,0, 2, "stall_before_reset");
        applyStimulus(1, 0, f_alu(4,3,5),   0, 0, 0,0,0,0, 0, "reset_mid_stall");
        applyStimulus(1, 1, f_alu(4,3,5),   0, 0, 0,0,0,0, 0, "post_reset_no_stall");

        // LOAD_LAT = 3 instance
        applyStimulus(3, 1, f_lw(8,0),      0, 0, 0,0,0,0, 0, "l3_lw8");
        applyStimulus(3, 1, f_alu(9,8,0),   0, 0, 1,1,0,0, 0, "l3_stall1");
        applyStimulus(3, 1, f_alu(9,8,0),   0, 0, 1,1,0,0, 1, "l3_stall2");
        applyStimulus(3, 1, f_alu(9,8,0),   0, 0, 1,1,0,0, 2, "l3_stall3");
        applyStimulus(3, 1, f_alu(9,8,0),   0, 0, 0,0,0,0, 3, "l3_release");
        applyStimulus(3, 1, f_lw(8,0),      0, 0, 0,0,0,0, 3, "l3_lw8_halt");
        applyStimulus(3, 1, f_nop(),        0, 1, 0,0,0,0, 3, "halt_req_run");
        applyStimulus(3, 1, f_nop(),        0, 1, 1,1,0,0, 3, "drain1");
        applyStimulus(3, 1, f_nop(),        0, 1, 1,1,0,0, 3, "drain2");
        applyStimulus(3, 1, f_nop(),        0, 1, 1,1,0,0, 3, "drain3");
        applyStimulus(3, 1, f_nop(),        0, 1, 1,1,0,1, 3, "halted");
        applyStimulus(3, 1, f_nop(),        0, 0, 1,1,0,1, 3, "halt_drop_same");
        applyStimulus(3, 1, f_nop(),        0, 0, 0,0,0,0, 3, "resume_run");
        applyStimulus(3, 1, f_nop(),        0, 1, 0,0,0,0, 3, "req_empty");
        applyStimulus(3, 1, f_nop(),        1, 1, 0,1,1,0, 3, "drain_flush");
        applyStimulus(3, 1, f_nop(),        0, 1, 1,1,0,1, 3, "empty_ack");
        applyStimulus(3, 1, f_nop(),        0, 0, 1,1,0,1, 3, "empty_drop");
        applyStimulus(3, 1, f_nop(),        0, 0, 0,0,0,0, 3, "empty_resume");
        applyStimulus(3, 1, f_lw(8,0),      0, 0, 0,0,0,0, 3, "lw8_abort");
        applyStimulus(3, 1, f_nop(),        0, 1, 0,0,0,0, 3, "abort_req");
        applyStimulus(3, 1, f_nop(),        0, 0, 1,1,0,0, 3, "drain_abort");
        applyStimulus(3, 1, f_nop(),        0, 0, 0,0,0,0, 3, "abort_run");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_queue: %0d entries left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
